// File: rtl/logic_result_stage.sv
// rtl/logic_result_stage.sv - registered result stage with 2-entry skid buffer and status flags
module logic_result_stage #(
    parameter int WIDTH = 8,
    parameter int OPW   = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_opcode,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_msb,
    output logic             out_illegal,
    output logic [CNT_W-1:0] res_count
);

    // Entry layout: {illegal, msb, parity, zero, y, opcode}
    localparam int EW = OPW + WIDTH + 4;
    localparam logic [EW-1:0] EMPTY_ENTRY = {4'b0001, {(WIDTH + OPW){1'b0}}};

    localparam logic [1:0] OCC0 = 2'd0;
    localparam logic [1:0] OCC1 = 2'd1;
    localparam logic [1:0] OCC2 = 2'd2;

    logic [EW-1:0]    h_q, h_d;
    logic [EW-1:0]    s_q, s_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc, pop;
    logic [EW-1:0]    new_entry;

    function automatic logic [EW-1:0] make_entry(input logic [OPW-1:0] op,
                                                 input logic [WIDTH-1:0] y);
        logic             legal;
        logic [WIDTH-1:0] ys;
        legal = (op >= OPW'(1)) && (op <= OPW'(7));
        ys    = legal ? y : '0;
        return {!legal, ys[WIDTH-1], ^ys, (ys == '0), ys, op};
    endfunction

    assign new_entry = make_entry(in_opcode, in_y);
    assign acc       = in_valid & in_ready_q;
    assign pop       = (occ_q != OCC0) & out_ready;

    always_comb begin
        h_d   = h_q;
        s_d   = s_q;
        occ_d = occ_q;
        cnt_d = acc ? cnt_q + CNT_W'(1) : cnt_q;
        case (occ_q)
            OCC0: begin
                if (acc) begin
                    h_d   = new_entry;
                    occ_d = OCC1;
                end
            end
            OCC1: begin
                if (acc && pop) begin
                    h_d = new_entry;
                end else if (acc) begin
                    s_d   = new_entry;
                    occ_d = OCC2;
                end else if (pop) begin
                    occ_d = OCC0;
                end
            end
            OCC2: begin
                // in_ready is low here, so only a pop can move the buffer
                if (pop) begin
                    h_d   = s_q;
                    occ_d = OCC1;
                end
            end
            default: occ_d = OCC0;
        endcase
        in_ready_d = (occ_d != OCC2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q        <= EMPTY_ENTRY;
            s_q        <= EMPTY_ENTRY;
            occ_q      <= OCC0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            h_q        <= h_d;
            s_q        <= s_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (occ_q != OCC0);
    assign out_opcode  = h_q[OPW-1:0];
    assign out_y       = h_q[OPW+WIDTH-1:OPW];
    assign out_zero    = h_q[EW-4];
    assign out_parity  = h_q[EW-3];
    assign out_msb     = h_q[EW-2];
    assign out_illegal = h_q[EW-1];
    assign res_count   = cnt_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// tb/tb_logic_result_stage.sv - directed table-driven bench for logic_result_stage
`timescale 1ns/1ps
module tb_logic_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_opcode;
    logic [7:0]  in_y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [7:0]  out_y;
    logic        out_zero;
    logic        out_parity;
    logic        out_msb;
    logic        out_illegal;
    logic [15:0] res_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    logic_result_stage #(.WIDTH(8), .OPW(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_y(out_y),
        .out_zero(out_zero), .out_parity(out_parity),
        .out_msb(out_msb), .out_illegal(out_illegal),
        .res_count(res_count)
    );

    typedef struct {
        logic [7:0] op;
        logic [7:0] y;
        logic [7:0] exp_y;
        logic       exp_zero;
        logic       exp_parity;
        logic       exp_msb;
        logic       exp_illegal;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input vec_t v);
        chk({name, ".valid"},   {31'd0, out_valid},   32'd1);
        chk({name, ".opcode"},  {24'd0, out_opcode},  {24'd0, v.op});
        chk({name, ".y"},       {24'd0, out_y},       {24'd0, v.exp_y});
        chk({name, ".zero"},    {31'd0, out_zero},    {31'd0, v.exp_zero});
        chk({name, ".parity"},  {31'd0, out_parity},  {31'd0, v.exp_parity});
        chk({name, ".msb"},     {31'd0, out_msb},     {31'd0, v.exp_msb});
        chk({name, ".illegal"}, {31'd0, out_illegal}, {31'd0, v.exp_illegal});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // A=0x0D, B=0x06 through opcodes 1..7, then illegal and boundary entries
        vecs[0]  = '{8'h01, 8'h04, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h02, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h03, 8'h0B, 8'h0B, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h04, 8'hFB, 8'hFB, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{8'h05, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8'h06, 8'hF4, 8'hF4, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{8'h07, 8'hF2, 8'hF2, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h08, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'hFF, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h07, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 8'h00; in_y = 8'h00; out_ready = 1'b0;
        tick(); tick();
        chk("rst.in_ready",  {31'd0, in_ready},    32'd0);
        chk("rst.out_valid", {31'd0, out_valid},   32'd0);
        chk("rst.out_y",     {24'd0, out_y},       32'd0);
        chk("rst.out_opcode",{24'd0, out_opcode},  32'd0);
        chk("rst.zero",      {31'd0, out_zero},    32'd1);
        chk("rst.parity",    {31'd0, out_parity},  32'd0);
        chk("rst.msb",       {31'd0, out_msb},     32'd0);
        chk("rst.illegal",   {31'd0, out_illegal}, 32'd0);
        chk("rst.count",     {16'd0, res_count},   32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel.in_ready_high", {31'd0, in_ready}, 32'd1);

        // Flow-through: one result per cycle with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_opcode = vecs[i].op; in_y = vecs[i].y;
            tick();
            exp_cnt++;
            chk_head($sformatf("flow%0d", i), vecs[i]);
            chk($sformatf("flow%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("flow.drained", {31'd0, out_valid}, 32'd0);
        chk("flow.count", {16'd0, res_count}, exp_cnt);

        // Backpressure: two accepts fill the buffer, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 8'h01; in_y = 8'h04;
        tick(); exp_cnt++;
        chk_head("bp.first", vecs[0]);
        chk("bp.in_ready1", {31'd0, in_ready}, 32'd1);
        in_opcode = 8'h02; in_y = 8'h0F;
        tick(); exp_cnt++;
        in_valid = 1'b0;
        chk("bp.in_ready_full", {31'd0, in_ready}, 32'd0);
        chk_head("bp.hold1", vecs[0]);
        tick();
        chk_head("bp.hold2", vecs[0]);
        chk("bp.count", {16'd0, res_count}, exp_cnt);
        out_ready = 1'b1;
        tick();
        chk_head("bp.second", vecs[1]);
        chk("bp.in_ready_again", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Accept and pop together at occupancy 1 for 10 cycles
        in_valid = 1'b1; in_opcode = 8'h02; in_y = 8'h10;
        tick(); exp_cnt++;
        for (int i = 0; i < 10; i++) begin
            in_y = 8'h20 + 8'(i);
            tick(); exp_cnt++;
            chk($sformatf("sim%0d.y", i), {24'd0, out_y}, 32'h20 + i);
            chk($sformatf("sim%0d.valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("sim%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("sim.count", {16'd0, res_count}, exp_cnt);
        chk("sim.drained", {31'd0, out_valid}, 32'd0);

        // Unknown data while idle must not disturb state
        in_opcode = 8'hxx; in_y = 8'hxx;
        tick(); tick();
        chk("idle.valid", {31'd0, out_valid}, 32'd0);
        chk("idle.count", {16'd0, res_count}, exp_cnt);

        // Asynchronous reset with the buffer full
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 8'h03; in_y = 8'h0B;
        tick(); tick();
        in_valid = 1'b0;
        chk("mrst.full", {31'd0, in_ready}, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst.valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.count", {16'd0, res_count}, 32'd0);
        chk("mrst.in_ready", {31'd0, in_ready}, 32'd0);
        chk("mrst.zero", {31'd0, out_zero}, 32'd1);
        chk("mrst.y", {24'd0, out_y}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst.rel_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("mrst.rel_high", {31'd0, in_ready}, 32'd1);
        chk("mrst.still_empty", {31'd0, out_valid}, 32'd0);

        // Counter wrap at 2^16
        out_ready = 1'b1;
        in_valid = 1'b1; in_opcode = 8'h01; in_y = 8'h55;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap.max", {16'd0, res_count}, 32'd65535);
        tick();
        chk("wrap.zero", {16'd0, res_count}, 32'd0);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
